// File: rtl/seq_pattern_tx_1011.sv
// Serial pattern transmitter: shifts parallel words out MSB-first on xout and
// produces zexp, the per-cycle output of an ideal overlapping Mealy PATTERN detector on xout.
module seq_pattern_tx_1011 #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [3:0]  PATTERN    = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             xout,
  output logic             xvalid,
  output logic             zexp,
  output logic             last,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic             GAP_EN   = (GAP_CYCLES != 0);
  localparam logic [7:0]       GAP_LAST = GAP_EN ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [7:0]       gap_cnt, gap_cnt_d;
  logic [2:0]       hist;
  logic             xout_d, xvalid_d;
  logic             accept;

  assign last      = (state == SHIFT) && (bit_cnt == LAST_IDX);
  assign busy      = (state != IDLE);
  // Back-to-back reload is only possible when no gap follows the word.
  assign din_ready = (state == IDLE) || (last && !GAP_EN);
  assign accept    = din_valid && din_ready;
  assign zexp      = ({hist, xout} == PATTERN);

  // Next-state and datapath.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    xout_d    = xout;
    xvalid_d  = xvalid;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          shreg_d   = {din[WIDTH-2:0], 1'b0};
          xout_d    = din[WIDTH-1];
          xvalid_d  = 1'b1;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          if (GAP_EN) begin
            state_d   = GAP;
            gap_cnt_d = 8'd0;
            xout_d    = 1'b0;
            xvalid_d  = 1'b0;
          end else if (accept) begin
            shreg_d   = {din[WIDTH-2:0], 1'b0};
            xout_d    = din[WIDTH-1];
            xvalid_d  = 1'b1;
            bit_cnt_d = '0;
          end else begin
            state_d  = IDLE;
            xout_d   = 1'b0;
            xvalid_d = 1'b0;
          end
        end else begin
          shreg_d   = {shreg[WIDTH-2:0], 1'b0};
          xout_d    = shreg[WIDTH-1];
          bit_cnt_d = bit_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        xout_d   = 1'b0;
        xvalid_d = 1'b0;
      end
    endcase
  end

  // State register; hist follows xout every cycle so zexp sees idle zeros too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= 8'd0;
      hist    <= 3'b000;
      xout    <= 1'b0;
      xvalid  <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      hist    <= {hist[1:0], xout};
      xout    <= xout_d;
      xvalid  <= xvalid_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx_1011.sv
// Bench for seq_pattern_tx_1011: three instances (gap 0, 3, 2) checked every cycle
// against a word-level reference model, plus directed pattern scenarios and random traffic.
module tb_seq_pattern_tx_1011;

  localparam int unsigned W    = 8;
  localparam int          N    = 3;
  localparam int          MAXW = 32;
  localparam logic [3:0]  PAT  = 4'b1011;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0][W-1:0] din;
  logic [N-1:0]        din_valid;
  logic [N-1:0]        din_ready;
  logic [N-1:0]        xout;
  logic [N-1:0]        xvalid;
  logic [N-1:0]        zexp;
  logic [N-1:0]        last;
  logic [N-1:0]        busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    seq_pattern_tx_1011 #(
      .WIDTH(W),
      .GAP_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .PATTERN(PAT)
    ) u_dut (
      .clk(clk), .rst(rst), .din(din[g]), .din_valid(din_valid[g]),
      .din_ready(din_ready[g]), .xout(xout[g]), .xvalid(xvalid[g]),
      .zexp(zexp[g]), .last(last[g]), .busy(busy[g])
    );
  end

  int gap_of [N] = '{0, 3, 2};

  // Reference model: bits of the word in flight, gap countdown, last three line values.
  int         npend    [N];
  logic [W-1:0] cur    [N];
  int         gap_left [N];
  logic [2:0] hist     [N];

  logic [W-1:0] words [N][MAXW];
  int   nwords [N];
  int   widx   [N];
  int   ridx   [N];
  logic vmask  [N];
  bit   rand_valid;

  int   zcnt [N];
  int   lcnt [N];
  int   run  [N];
  int   maxrun [N];
  logic [W-1:0] rx [N];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      vmask[i]     = (rand_valid && i != 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      din_valid[i] = vmask[i] && (widx[i] < nwords[i]);
      din[i]       = words[i][widx[i] % MAXW];
    end
  endtask

  task automatic new_phase();
    for (int i = 0; i < N; i++) begin
      zcnt[i] = 0; lcnt[i] = 0; run[i] = 0; maxrun[i] = 0;
      nwords[i] = 0; widx[i] = 0; ridx[i] = 0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] ex;
    logic [N-1:0] acc;
    logic         er;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ex[i] = (npend[i] > 0) ? cur[i][3'(npend[i] - 1)] : 1'b0;
      er    = (npend[i] == 0 && gap_left[i] == 0) || (gap_of[i] == 0 && npend[i] == 1);
      check($sformatf("xout[%0d]", i),      32'(xout[i]),      32'(ex[i]));
      check($sformatf("xvalid[%0d]", i),    32'(xvalid[i]),    32'(npend[i] > 0));
      check($sformatf("last[%0d]", i),      32'(last[i]),      32'(npend[i] == 1));
      check($sformatf("busy[%0d]", i),      32'(busy[i]),      32'(npend[i] > 0 || gap_left[i] > 0));
      check($sformatf("din_ready[%0d]", i), 32'(din_ready[i]), 32'(er));
      check($sformatf("zexp[%0d]", i),      32'(zexp[i]),      32'({hist[i], ex[i]} == PAT));
      zcnt[i] += int'(zexp[i]);
      lcnt[i] += int'(last[i]);
      run[i]   = (xvalid[i] === 1'b1) ? run[i] + 1 : 0;
      if (run[i] > maxrun[i]) maxrun[i] = run[i];
      if (xvalid[i] === 1'b1) rx[i] = {rx[i][W-2:0], xout[i]};
      if (last[i] === 1'b1) begin
        check($sformatf("rxword[%0d]", i), 32'(rx[i]), 32'(words[i][ridx[i] % MAXW]));
        ridx[i]++;
      end
      acc[i] = rst && din_valid[i] && er;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        npend[i] = 0; gap_left[i] = 0; hist[i] = 3'b000; ridx[i] = widx[i];
      end else begin
        hist[i] = {hist[i][1:0], ex[i]};
        if (npend[i] > 0) begin
          npend[i]--;
          if (npend[i] == 0) gap_left[i] = gap_of[i];
        end else if (gap_left[i] > 0) begin
          gap_left[i]--;
        end
        if (acc[i]) begin
          cur[i]   = din[i];
          npend[i] = int'(W);
          widx[i]++;
        end
      end
    end
    #1;
    drive();
  endtask

  initial begin
    rst        = 1'b0;
    rand_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      npend[i] = 0; gap_left[i] = 0; hist[i] = 3'b000; cur[i] = '0; rx[i] = '0;
    end
    new_phase();
    drive();
    @(posedge clk);
    #1;

    // Reset held with a word offered, then a single 1011_1011 word.
    for (int i = 0; i < N; i++) begin
      words[i][0] = 8'b1011_1011;
      nwords[i]   = 1;
    end
    drive();
    repeat (3) cycle();
    rst = 1'b1;
    repeat (14) cycle();
    for (int i = 0; i < N; i++) begin
      check($sformatf("single_zexp_cnt[%0d]", i), 32'(zcnt[i]), 32'd2);
      check($sformatf("single_last_cnt[%0d]", i), 32'(lcnt[i]), 32'd1);
      check($sformatf("single_words[%0d]", i),    32'(ridx[i]), 32'd1);
    end

    // Two words spanning a word boundary; the 1011 survives only without a gap.
    new_phase();
    for (int i = 0; i < N; i++) begin
      words[i][0] = 8'b0000_0101;
      words[i][1] = 8'b1000_0000;
      nwords[i]   = 2;
    end
    drive();
    repeat (40) cycle();
    for (int i = 0; i < N; i++) begin
      check($sformatf("span_zexp_cnt[%0d]", i), 32'(zcnt[i]),   (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("span_run[%0d]", i),      32'(maxrun[i]), (i == 0) ? 32'd16 : 32'd8);
      check($sformatf("span_words[%0d]", i),    32'(ridx[i]),   32'd2);
    end

    // Reset in mid-word after 1,0,1 then a word starting with 1: history must be cleared.
    new_phase();
    for (int i = 0; i < N; i++) begin
      words[i][0] = 8'b1010_0000;
      nwords[i]   = 1;
    end
    drive();
    for (int k = 0; k < 20 && npend[0] != 6; k++) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      words[i][1] = 8'b1000_0000;
      nwords[i]   = 2;
    end
    drive();
    repeat (20) cycle();
    for (int i = 0; i < N; i++) begin
      check($sformatf("abort_zexp_cnt[%0d]", i), 32'(zcnt[i]), 32'd0);
      check($sformatf("abort_last_cnt[%0d]", i), 32'(lcnt[i]), 32'd1);
      check($sformatf("abort_words[%0d]", i),    32'(ridx[i]), 32'd2);
    end

    // Random words; instance 2 keeps din_valid high throughout.
    new_phase();
    rand_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 16; k++)
        words[i][k] = (k % 4 == 0) ? 8'b1011_1011 : 8'($urandom);
      nwords[i] = 16;
    end
    drive();
    for (int k = 0; k < 800 && !(ridx[0] == 16 && ridx[1] == 16 && ridx[2] == 16); k++) cycle();
    for (int i = 0; i < N; i++)
      check($sformatf("rand_words[%0d]", i), 32'(ridx[i]), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
